// File: rtl/ex_memreq_stage.sv
// EX stage: forms rj+imm, flags misaligned accesses, and issues the data SRAM
// request with a req/addr_ok handshake, draining any request a flush leaves in flight.
module ex_memreq_stage #(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 later_excep,
  input  logic                 in_valid,
  output logic                 ex_allowin,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_rj,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_rkd,
  input  logic                 in_mem_re,
  input  logic                 in_mem_we,
  input  logic [1:0]           in_mem_size,
  input  logic                 in_mem_unsigned,
  input  logic                 in_excep,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 mem_allowin,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_addr,
  output logic                 out_ale,
  output logic                 out_excep,
  output logic                 out_mem_issued,
  output logic [1:0]           out_mem_size,
  output logic                 out_mem_unsigned,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 mem_drop_resp,
  output logic                 data_sram_req,
  output logic                 data_sram_wr,
  output logic [1:0]           data_sram_size,
  output logic [3:0]           data_sram_wstrb,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata,
  input  logic                 data_sram_addr_ok
);

  typedef enum logic [1:0] {IDLE, ISSUE, READY, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        req_held;
  logic [31:0] rkd_q;
  logic        mem_re_q, mem_we_q, excep_q;
  logic        accept, accept_issue, kill, req_fire;

  assign accept       = in_valid & ex_allowin & ~flush;
  assign accept_issue = (in_mem_re | in_mem_we) & ~in_excep;
  assign kill         = out_ale | later_excep;
  assign req_fire     = data_sram_req & data_sram_addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Flush wins over everything; a request already on the bus must still complete.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      if (req_fire)           state_nxt = IDLE;
      else if (data_sram_req) state_nxt = DRAIN;
      else                    state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = accept_issue ? ISSUE : READY;
        ISSUE: begin
          if (kill & ~req_held)       state_nxt = READY;
          else if (data_sram_addr_ok) state_nxt = READY;
        end
        READY: begin
          if (accept)           state_nxt = accept_issue ? ISSUE : READY;
          else if (mem_allowin) state_nxt = IDLE;
        end
        DRAIN: if (data_sram_addr_ok) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Once req has been shown without addr_ok it must stay up, so kill only suppresses a fresh req.
  always_comb begin
    ex_allowin    = (state == IDLE) | ((state == READY) & mem_allowin);
    out_valid     = (state == READY);
    data_sram_req = ((state == ISSUE) & (req_held | ~kill)) | (state == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_held       <= 1'b0;
      out_mem_issued <= 1'b0;
      mem_drop_resp  <= 1'b0;
    end else begin
      req_held      <= data_sram_req & ~data_sram_addr_ok;
      mem_drop_resp <= req_fire & (flush | (state == DRAIN));
      if (flush | accept)
        out_mem_issued <= 1'b0;
      else if ((state == ISSUE) & req_fire)
        out_mem_issued <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_pc           <= '0;
      out_addr         <= '0;
      rkd_q            <= '0;
      mem_re_q         <= 1'b0;
      mem_we_q         <= 1'b0;
      out_mem_size     <= '0;
      out_mem_unsigned <= 1'b0;
      excep_q          <= 1'b0;
      out_payload      <= '0;
    end else if (accept) begin
      out_pc           <= in_pc;
      out_addr         <= in_rj + in_imm;
      rkd_q            <= in_rkd;
      mem_re_q         <= in_mem_re;
      mem_we_q         <= in_mem_we;
      out_mem_size     <= in_mem_size;
      out_mem_unsigned <= in_mem_unsigned;
      excep_q          <= in_excep;
      out_payload      <= in_payload;
    end
  end

  // Alignment only matters for instructions that actually touch memory.
  always_comb begin
    out_ale = (mem_re_q | mem_we_q) &
              (((out_mem_size == 2'd1) & out_addr[0]) |
               ((out_mem_size == 2'd2) & (out_addr[1:0] != 2'b00)));
    out_excep = excep_q | out_ale;
  end

  always_comb begin
    data_sram_wr   = mem_we_q;
    data_sram_size = out_mem_size;
    data_sram_addr = out_addr;
    case (out_mem_size)
      2'd0: begin
        data_sram_wstrb = 4'b0001 << out_addr[1:0];
        data_sram_wdata = {4{rkd_q[7:0]}};
      end
      2'd1: begin
        data_sram_wstrb = out_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rkd_q[15:0]}};
      end
      default: begin
        data_sram_wstrb = 4'b1111;
        data_sram_wdata = rkd_q;
      end
    endcase
    if (!mem_we_q) data_sram_wstrb = 4'b0000;
  end

endmodule

// File: tb/tb_ex_memreq_stage.sv
// Scoreboard bench for ex_memreq_stage: stimulus pushes hand-computed results,
// a negedge monitor pops them on SRAM handshakes, MEM handshakes and drop pulses.
module tb_ex_memreq_stage;

  typedef struct {
    logic [31:0] pc, rj, imm, rkd;
    logic        re, we;
    logic [1:0]  size;
    logic        uns, excep;
    logic [63:0] payload;
  } instr_t;

  typedef struct {
    logic [31:0] pc, addr;
    logic        ale, excep, issued;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] payload;
  } result_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic        chk_wdata;
  } req_t;

  logic        clk, resetn, flush, later_excep, in_valid, ex_allowin;
  logic [31:0] in_pc, in_rj, in_imm, in_rkd;
  logic        in_mem_re, in_mem_we, in_mem_unsigned, in_excep;
  logic [1:0]  in_mem_size;
  logic [63:0] in_payload;
  logic        out_valid, mem_allowin, out_ale, out_excep, out_mem_issued;
  logic [31:0] out_pc, out_addr;
  logic [1:0]  out_mem_size;
  logic        out_mem_unsigned;
  logic [63:0] out_payload;
  logic        mem_drop_resp, data_sram_req, data_sram_wr, data_sram_addr_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;

  ex_memreq_stage #(.PAYLOAD_W(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .later_excep(later_excep),
    .in_valid(in_valid), .ex_allowin(ex_allowin),
    .in_pc(in_pc), .in_rj(in_rj), .in_imm(in_imm), .in_rkd(in_rkd),
    .in_mem_re(in_mem_re), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_excep(in_excep), .in_payload(in_payload),
    .out_valid(out_valid), .mem_allowin(mem_allowin),
    .out_pc(out_pc), .out_addr(out_addr), .out_ale(out_ale), .out_excep(out_excep),
    .out_mem_issued(out_mem_issued), .out_mem_size(out_mem_size),
    .out_mem_unsigned(out_mem_unsigned), .out_payload(out_payload),
    .mem_drop_resp(mem_drop_resp),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      tests_run = 0;
  int      failed    = 0;
  int      req_cycles = 0;
  int      ok_delay  = 0;
  bit      mon_en    = 0;
  result_t res_q[$];
  req_t    req_q[$];
  bit      drop_q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests_run++;
    failed++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic instr_t mkInstr(logic [31:0] pc, rj, imm, rkd, logic re, we,
                                     logic [1:0] size, logic uns, excep, logic [63:0] payload);
    instr_t i;
    i.pc = pc; i.rj = rj; i.imm = imm; i.rkd = rkd; i.re = re; i.we = we;
    i.size = size; i.uns = uns; i.excep = excep; i.payload = payload;
    return i;
  endfunction

  function automatic result_t mkRes(logic [31:0] pc, addr, logic ale, excep, issued,
                                    logic [1:0] size, logic uns, logic [63:0] payload);
    result_t r;
    r.pc = pc; r.addr = addr; r.ale = ale; r.excep = excep; r.issued = issued;
    r.size = size; r.uns = uns; r.payload = payload;
    return r;
  endfunction

  function automatic req_t mkReq(logic [31:0] addr, wdata, logic wr, logic [1:0] size,
                                 logic [3:0] wstrb, logic chk_wdata);
    req_t q;
    q.addr = addr; q.wdata = wdata; q.wr = wr; q.size = size;
    q.wstrb = wstrb; q.chk_wdata = chk_wdata;
    return q;
  endfunction

  task automatic driveInstr(input instr_t i);
    in_pc = i.pc; in_rj = i.rj; in_imm = i.imm; in_rkd = i.rkd;
    in_mem_re = i.re; in_mem_we = i.we; in_mem_size = i.size;
    in_mem_unsigned = i.uns; in_excep = i.excep; in_payload = i.payload;
    in_valid = 1'b1;
  endtask

  // Expectations are queued at the handshake that hands the instruction to EX.
  task automatic waitAccept(input bit has_res, input result_t r, input bit has_req, input req_t q);
    bit got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_valid && ex_allowin && !flush) begin
        got = 1;
        if (has_res) res_q.push_back(r);
        if (has_req) req_q.push_back(q);
      end
    end
    if (!got) timeoutFail("accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input instr_t i, input bit has_res, input result_t r,
                               input bit has_req, input req_t q);
    driveInstr(i);
    waitAccept(has_res, r, has_req, q);
  endtask

  task automatic waitDrain();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk);
      if (res_q.size() == 0 && req_q.size() == 0 && drop_q.size() == 0) done = 1;
    end
    if (!done) timeoutFail("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // SRAM model: addr_ok rises after ok_delay cycles of req being held.
  initial begin
    int cnt = 0;
    data_sram_addr_ok = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (data_sram_req) begin
        data_sram_addr_ok = (cnt >= ok_delay);
        cnt = data_sram_addr_ok ? 0 : cnt + 1;
      end else begin
        data_sram_addr_ok = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    result_t e;
    req_t    q;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (data_sram_req) req_cycles++;
        if (data_sram_req && data_sram_addr_ok) begin
          if (req_q.size() == 0) begin
            timeoutFail("unexpected_sram_req");
          end else begin
            q = req_q.pop_front();
            checkOutput("req_addr",  64'(data_sram_addr),  64'(q.addr));
            checkOutput("req_wr",    64'(data_sram_wr),    64'(q.wr));
            checkOutput("req_size",  64'(data_sram_size),  64'(q.size));
            checkOutput("req_wstrb", 64'(data_sram_wstrb), 64'(q.wstrb));
            if (q.chk_wdata) checkOutput("req_wdata", 64'(data_sram_wdata), 64'(q.wdata));
          end
        end
        if (out_valid && mem_allowin) begin
          if (res_q.size() == 0) begin
            timeoutFail("unexpected_out_valid");
          end else begin
            e = res_q.pop_front();
            checkOutput("res_pc",      64'(out_pc),           64'(e.pc));
            checkOutput("res_addr",    64'(out_addr),         64'(e.addr));
            checkOutput("res_ale",     64'(out_ale),          64'(e.ale));
            checkOutput("res_excep",   64'(out_excep),        64'(e.excep));
            checkOutput("res_issued",  64'(out_mem_issued),   64'(e.issued));
            checkOutput("res_size",    64'(out_mem_size),     64'(e.size));
            checkOutput("res_uns",     64'(out_mem_unsigned), 64'(e.uns));
            checkOutput("res_payload", out_payload,           e.payload);
          end
        end
        if (mem_drop_resp) begin
          if (drop_q.size() == 0) timeoutFail("unexpected_drop_resp");
          else void'(drop_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    req_t nreq;
    result_t nres;
    nreq = mkReq(0, 0, 0, 0, 0, 0);
    nres = mkRes(0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0; flush = 1'b0; later_excep = 1'b0; in_valid = 1'b0;
    mem_allowin = 1'b1;
    driveInstr(mkInstr(32'h1c00_0000, 32'h5555_5555, 32'h1, 32'h1, 1, 1, 2'd1, 1, 1, 64'hFF));
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid),      64'd0);
    checkOutput("rst_req",       64'(data_sram_req),  64'd0);
    checkOutput("rst_out_addr",  64'(out_addr),       64'd0);
    checkOutput("rst_issued",    64'(out_mem_issued), 64'd0);
    checkOutput("rst_drop",      64'(mem_drop_resp),  64'd0);
    checkOutput("rst_allowin",   64'(ex_allowin),     64'd1);
    checkOutput("rst_payload",   out_payload,         64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; resetn = 1'b1; mon_en = 1'b1;

    // ld.w with addr_ok held off for two cycles
    ok_delay = 2;
    base = req_cycles;
    applyStimulus(mkInstr(32'h1c00_0000, 32'h1c00_0100, 32'h4, 32'h1122_3344, 1, 0, 2'd2, 0, 0, 64'h1111),
                  1, mkRes(32'h1c00_0000, 32'h1c00_0104, 0, 0, 1, 2'd2, 0, 64'h1111),
                  1, mkReq(32'h1c00_0104, 0, 0, 2'd2, 4'b0000, 0));
    waitDrain();
    checkOutput("t1_req_cycles", 64'(req_cycles - base), 64'd3);

    // st.b at byte offset 3
    ok_delay = 0;
    applyStimulus(mkInstr(32'h1c00_0004, 32'h1c00_0000, 32'h3, 32'h0000_00AB, 0, 1, 2'd0, 0, 0, 64'h2222),
                  1, mkRes(32'h1c00_0004, 32'h1c00_0003, 0, 0, 1, 2'd0, 0, 64'h2222),
                  1, mkReq(32'h1c00_0003, 32'hABAB_ABAB, 1, 2'd0, 4'b1000, 1));
    // st.h to the upper half
    applyStimulus(mkInstr(32'h1c00_0008, 32'h1c00_0000, 32'h2, 32'h1234_CDEF, 0, 1, 2'd1, 0, 0, 64'h3333),
                  1, mkRes(32'h1c00_0008, 32'h1c00_0002, 0, 0, 1, 2'd1, 0, 64'h3333),
                  1, mkReq(32'h1c00_0002, 32'hCDEF_CDEF, 1, 2'd1, 4'b1100, 1));
    // st.w whose address wraps around 2^32
    applyStimulus(mkInstr(32'h1c00_000c, 32'h0000_0004, 32'hFFFF_FFF8, 32'hDEAD_BEEF, 0, 1, 2'd2, 0, 0, 64'h4444),
                  1, mkRes(32'h1c00_000c, 32'hFFFF_FFFC, 0, 0, 1, 2'd2, 0, 64'h4444),
                  1, mkReq(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 2'd2, 4'b1111, 1));
    waitDrain();

    // Misaligned ld.h and a load carrying an upstream exception never reach the SRAM
    base = req_cycles;
    applyStimulus(mkInstr(32'h1c00_0010, 32'h1c00_0000, 32'h1, 32'h0, 1, 0, 2'd1, 1, 0, 64'h5555),
                  1, mkRes(32'h1c00_0010, 32'h1c00_0001, 1, 1, 0, 2'd1, 1, 64'h5555), 0, nreq);
    applyStimulus(mkInstr(32'h1c00_0014, 32'h1c00_0000, 32'h8, 32'h0, 1, 0, 2'd2, 0, 1, 64'h6666),
                  1, mkRes(32'h1c00_0014, 32'h1c00_0008, 0, 1, 0, 2'd2, 0, 64'h6666), 0, nreq);
    waitDrain();
    checkOutput("t3_req_cycles", 64'(req_cycles - base), 64'd0);

    // Flush while st.w waits for addr_ok: request drains, then drop pulse
    ok_delay = 3;
    drop_q.push_back(1'b1);
    applyStimulus(mkInstr(32'h1c00_0018, 32'h1c00_0200, 32'h8, 32'h7777_8888, 0, 1, 2'd2, 0, 0, 64'h7777),
                  0, nres, 1, mkReq(32'h1c00_0208, 32'h7777_8888, 1, 2'd2, 4'b1111, 1));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    begin
      bit seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        checkOutput("t4_req_held",  64'(data_sram_req), 64'd1);
        checkOutput("t4_allowin",   64'(ex_allowin),    64'd0);
        checkOutput("t4_out_valid", 64'(out_valid),     64'd0);
        seen = data_sram_addr_ok;
      end
      if (!seen) timeoutFail("t4_addr_ok");
    end
    waitDrain();
    checkOutput("t4_idle_valid",   64'(out_valid),  64'd0);
    checkOutput("t4_idle_allowin", 64'(ex_allowin), 64'd1);

    // Flush in the same cycle addr_ok accepts the request
    ok_delay = 0;
    drop_q.push_back(1'b1);
    applyStimulus(mkInstr(32'h1c00_001c, 32'h1c00_0300, 32'h0, 32'h0BAD_F00D, 0, 1, 2'd2, 0, 0, 64'h8888),
                  0, nres, 1, mkReq(32'h1c00_0300, 32'h0BAD_F00D, 1, 2'd2, 4'b1111, 1));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    waitDrain();
    checkOutput("t4b_out_valid", 64'(out_valid), 64'd0);

    // later_excep kills a fresh request; the following instruction still flows
    base = req_cycles;
    later_excep = 1'b1;
    applyStimulus(mkInstr(32'h1c00_0020, 32'h1c00_0400, 32'h4, 32'h0, 1, 0, 2'd2, 0, 0, 64'h9999),
                  1, mkRes(32'h1c00_0020, 32'h1c00_0404, 0, 0, 0, 2'd2, 0, 64'h9999), 0, nreq);
    waitDrain();
    checkOutput("t5_req_cycles", 64'(req_cycles - base), 64'd0);
    later_excep = 1'b0;
    applyStimulus(mkInstr(32'h1c00_0024, 32'h0000_0010, 32'h0000_0020, 32'h0, 0, 0, 2'd0, 0, 0, 64'hAAAA),
                  1, mkRes(32'h1c00_0024, 32'h0000_0030, 0, 0, 0, 2'd0, 0, 64'hAAAA), 0, nreq);
    waitDrain();

    // MEM back-pressure: result held stable, next instruction waits for mem_allowin
    mem_allowin = 1'b0;
    applyStimulus(mkInstr(32'h1c00_0100, 32'h5, 32'h7, 32'h0, 0, 0, 2'd0, 0, 0, 64'hBBBB),
                  1, mkRes(32'h1c00_0100, 32'h0000_000C, 0, 0, 0, 2'd0, 0, 64'hBBBB), 0, nreq);
    driveInstr(mkInstr(32'h1c00_0104, 32'h100, 32'h1, 32'h0, 0, 0, 2'd0, 0, 0, 64'hCCCC));
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_allowin",   64'(ex_allowin), 64'd0);
      checkOutput("t6_out_valid", 64'(out_valid),  64'd1);
      checkOutput("t6_out_pc",    64'(out_pc),     64'h1c00_0100);
      checkOutput("t6_out_addr",  64'(out_addr),   64'h0000_000C);
    end
    @(posedge clk);
    #1 mem_allowin = 1'b1;
    waitAccept(1, mkRes(32'h1c00_0104, 32'h0000_0101, 0, 0, 0, 2'd0, 0, 64'hCCCC), 0, nreq);
    waitDrain();

    checkOutput("end_res_q",  64'(res_q.size()),  64'd0);
    checkOutput("end_req_q",  64'(req_q.size()),  64'd0);
    checkOutput("end_drop_q", 64'(drop_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
